// File: rtl/ic_req_arb_if.sv
// Signal bundle between the demand/prefetch requesters, the fetch arbiter and the icache.
// The arbiter uses the slave view; the surrounding requesters/icache use the master view.
interface ic_req_arb_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned CL_BITS   = 512,
    parameter int unsigned MAX_OUTST = 4
);
    localparam int unsigned SLOT_W = $clog2(MAX_OUTST);

    logic                flush;

    logic                dm_req_valid;
    logic                dm_req_ready;
    logic [ID_W-1:0]     dm_req_id;
    logic [ADDR_W-1:0]   dm_req_addr;

    logic                pf_req_valid;
    logic                pf_req_ready;
    logic [ID_W-1:0]     pf_req_id;
    logic [ADDR_W-1:0]   pf_req_addr;

    logic                ic_req_valid;
    logic [SLOT_W-1:0]   ic_req_id;
    logic [ADDR_W-1:0]   ic_req_addr;

    logic                ic_rsp_valid;
    logic [SLOT_W-1:0]   ic_rsp_id;
    logic [CL_BITS-1:0]  ic_rsp_data;

    logic                dm_rsp_valid;
    logic [ID_W-1:0]     dm_rsp_id;
    logic [CL_BITS-1:0]  dm_rsp_data;

    logic                pf_rsp_valid;
    logic [ID_W-1:0]     pf_rsp_id;
    logic [CL_BITS-1:0]  pf_rsp_data;

    modport slave (
        input  flush,
        input  dm_req_valid, dm_req_id, dm_req_addr,
        output dm_req_ready,
        input  pf_req_valid, pf_req_id, pf_req_addr,
        output pf_req_ready,
        output ic_req_valid, ic_req_id, ic_req_addr,
        input  ic_rsp_valid, ic_rsp_id, ic_rsp_data,
        output dm_rsp_valid, dm_rsp_id, dm_rsp_data,
        output pf_rsp_valid, pf_rsp_id, pf_rsp_data
    );

    modport master (
        output flush,
        output dm_req_valid, dm_req_id, dm_req_addr,
        input  dm_req_ready,
        output pf_req_valid, pf_req_id, pf_req_addr,
        input  pf_req_ready,
        input  ic_req_valid, ic_req_id, ic_req_addr,
        output ic_rsp_valid, ic_rsp_id, ic_rsp_data,
        input  dm_rsp_valid, dm_rsp_id, dm_rsp_data,
        input  pf_rsp_valid, pf_rsp_id, pf_rsp_data
    );
endinterface

// File: rtl/ic_req_arb.sv
// Demand/prefetch fetch arbiter: tags each accepted request with a free slot index for the
// icache and routes each icache response back to its owner with the original id restored.
module ic_req_arb #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned CL_BITS    = 512,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input logic         clk,
    input logic         reset,
    ic_req_arb_if.slave bus
);
    localparam int unsigned SLOT_W = $clog2(MAX_OUTST);

    typedef logic [SLOT_W-1:0] slot_t;

    // Slot table; owner bit set means the prefetch requester owns the slot.
    logic [MAX_OUTST-1:0] busy_q, busy_d;
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [MAX_OUTST-1:0] drop_q, drop_d;
    logic [ID_W-1:0]      id_q [MAX_OUTST];

    logic [7:0]           starve_q, starve_d;

    logic                 ic_req_valid_q;
    slot_t                ic_req_id_q;
    logic [ADDR_W-1:0]    ic_req_addr_q;

    logic                 dm_rsp_valid_q, dm_rsp_valid_d;
    logic [ID_W-1:0]      dm_rsp_id_q;
    logic [CL_BITS-1:0]   dm_rsp_data_q;
    logic                 pf_rsp_valid_q, pf_rsp_valid_d;
    logic [ID_W-1:0]      pf_rsp_id_q;
    logic [CL_BITS-1:0]   pf_rsp_data_q;

    logic                 have_free;
    slot_t                free_slot;
    logic                 starved;
    logic                 dm_win, pf_win;
    logic                 can_accept;
    logic                 dm_acc, pf_acc, acc;
    logic [ID_W-1:0]      acc_id;
    logic [ADDR_W-1:0]    acc_addr;
    slot_t                rsp_slot;
    logic                 rsp_hit, rsp_fwd;

    // Lowest-index free slot, judged on registered busy state only.
    always_comb begin
        have_free = 1'b0;
        free_slot = '0;
        for (int i = int'(MAX_OUTST) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                have_free = 1'b1;
                free_slot = slot_t'(i);
            end
        end
    end

    always_comb begin
        starved    = (starve_q == 8'(STARVE_LIM));
        pf_win     = bus.pf_req_valid & (~bus.dm_req_valid | starved);
        dm_win     = bus.dm_req_valid & ~pf_win;
        can_accept = reset & ~bus.flush & have_free;
        dm_acc     = dm_win & can_accept;
        pf_acc     = pf_win & can_accept;
        acc        = dm_acc | pf_acc;
        acc_id     = pf_acc ? bus.pf_req_id : bus.dm_req_id;
        acc_addr   = pf_acc ? bus.pf_req_addr : bus.dm_req_addr;
    end

    assign bus.dm_req_ready = dm_acc;
    assign bus.pf_req_ready = pf_acc;

    always_comb begin
        rsp_slot       = bus.ic_rsp_id;
        rsp_hit        = bus.ic_rsp_valid & busy_q[rsp_slot];
        rsp_fwd        = rsp_hit & ~drop_q[rsp_slot] & ~bus.flush;
        dm_rsp_valid_d = rsp_fwd & ~owner_q[rsp_slot];
        pf_rsp_valid_d = rsp_fwd & owner_q[rsp_slot];
    end

    // A flush can never coincide with an allocation, and a freed slot is never the one allocated,
    // so the order of these updates does not matter.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        if (bus.flush) begin
            drop_d = drop_q | busy_q;
        end
        if (rsp_hit) begin
            busy_d[rsp_slot] = 1'b0;
        end
        if (acc) begin
            busy_d[free_slot]  = 1'b1;
            owner_d[free_slot] = pf_acc;
            drop_d[free_slot]  = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (pf_acc) begin
            starve_d = '0;
        end else if (bus.pf_req_valid && !starved) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q         <= '0;
            owner_q        <= '0;
            drop_q         <= '0;
            starve_q       <= '0;
            ic_req_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            pf_rsp_valid_q <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            owner_q        <= owner_d;
            drop_q         <= drop_d;
            starve_q       <= starve_d;
            ic_req_valid_q <= acc;
            dm_rsp_valid_q <= dm_rsp_valid_d;
            pf_rsp_valid_q <= pf_rsp_valid_d;
        end
    end

    // Datapath registers load only with their qualifying valid and need no reset.
    always_ff @(posedge clk) begin
        if (acc) begin
            id_q[free_slot] <= acc_id;
            ic_req_id_q     <= free_slot;
            ic_req_addr_q   <= acc_addr;
        end
        if (dm_rsp_valid_d) begin
            dm_rsp_id_q   <= id_q[rsp_slot];
            dm_rsp_data_q <= bus.ic_rsp_data;
        end
        if (pf_rsp_valid_d) begin
            pf_rsp_id_q   <= id_q[rsp_slot];
            pf_rsp_data_q <= bus.ic_rsp_data;
        end
    end

    assign bus.ic_req_valid = ic_req_valid_q;
    assign bus.ic_req_id    = ic_req_id_q;
    assign bus.ic_req_addr  = ic_req_addr_q;
    assign bus.dm_rsp_valid = dm_rsp_valid_q;
    assign bus.dm_rsp_id    = dm_rsp_id_q;
    assign bus.dm_rsp_data  = dm_rsp_data_q;
    assign bus.pf_rsp_valid = pf_rsp_valid_q;
    assign bus.pf_rsp_id    = pf_rsp_id_q;
    assign bus.pf_rsp_data  = pf_rsp_data_q;

    rsp_to_idle_slot: assert property (
        @(posedge clk) disable iff (!reset) bus.ic_rsp_valid |-> busy_q[bus.ic_rsp_id]
    ) else $error("ic_req_arb: icache response for idle slot %0d", bus.ic_rsp_id);

endmodule

// File: tb/tb_ic_req_arb.sv
// Bench for ic_req_arb: a slot-table reference model predicts ready, icache requests and
// owner responses; predictions are queued and compared as the DUT produces them.
module tb_ic_req_arb;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned CL_BITS    = 512;
    localparam int unsigned MAX_OUTST  = 4;
    localparam int unsigned STARVE_LIM = 8;
    localparam int unsigned SLOT_W     = $clog2(MAX_OUTST);

    typedef logic [CL_BITS-1:0] val_t;

    typedef struct {
        logic [SLOT_W-1:0] slot;
        logic [ADDR_W-1:0] addr;
    } ic_exp_t;

    typedef struct {
        bit                 pf;
        logic [ID_W-1:0]    id;
        logic [CL_BITS-1:0] data;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    ic_req_arb_if #(
        .ADDR_W   (ADDR_W),
        .ID_W     (ID_W),
        .CL_BITS  (CL_BITS),
        .MAX_OUTST(MAX_OUTST)
    ) bus ();

    ic_req_arb #(
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .CL_BITS   (CL_BITS),
        .MAX_OUTST (MAX_OUTST),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;

    // Reference model of the slot table and starvation counter.
    bit              m_busy [MAX_OUTST];
    bit              m_pf   [MAX_OUTST];
    bit              m_drop [MAX_OUTST];
    logic [ID_W-1:0] m_id   [MAX_OUTST];
    int              m_starve = 0;

    ic_exp_t  icq[$];
    rsp_exp_t rspq[$];

    bit acc_dm, acc_pf, ic_seen;
    int last_slot;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic val_t rand_line();
        val_t v;
        for (int i = 0; i < int'(CL_BITS / 32); i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic respond(input int slot);
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_id    = SLOT_W'(slot);
        bus.ic_rsp_data  = rand_line();
    endtask

    // One clock: predict and check ready before the edge, update the model, then check the
    // registered outputs at the following falling edge. Called and returns at a falling edge.
    task automatic tick();
        bit       have_free, starved, pf_w, dm_w, rdy_dm, rdy_pf;
        int       fs, s;
        ic_exp_t  ie;
        rsp_exp_t re;
        #1;
        have_free = 1'b0;
        fs = 0;
        for (int i = int'(MAX_OUTST) - 1; i >= 0; i--) begin
            if (!m_busy[i]) begin
                have_free = 1'b1;
                fs = i;
            end
        end
        starved = (m_starve == int'(STARVE_LIM));
        pf_w    = bus.pf_req_valid && (!bus.dm_req_valid || starved);
        dm_w    = bus.dm_req_valid && !pf_w;
        rdy_dm  = reset && !bus.flush && have_free && dm_w;
        rdy_pf  = reset && !bus.flush && have_free && pf_w;
        check("dm_req_ready", val_t'(bus.dm_req_ready), val_t'(rdy_dm));
        check("pf_req_ready", val_t'(bus.pf_req_ready), val_t'(rdy_pf));
        acc_dm = rdy_dm;
        acc_pf = rdy_pf;
        if (!reset) begin
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                m_busy[i] = 1'b0;
                m_drop[i] = 1'b0;
            end
            m_starve = 0;
        end else begin
            if (bus.flush) begin
                for (int i = 0; i < int'(MAX_OUTST); i++) if (m_busy[i]) m_drop[i] = 1'b1;
            end
            if (bus.ic_rsp_valid) begin
                s = int'(bus.ic_rsp_id);
                if (m_busy[s]) begin
                    if (!m_drop[s] && !bus.flush) begin
                        re.pf   = m_pf[s];
                        re.id   = m_id[s];
                        re.data = bus.ic_rsp_data;
                        rspq.push_back(re);
                    end
                    m_busy[s] = 1'b0;
                end
            end
            if (rdy_dm || rdy_pf) begin
                m_busy[fs] = 1'b1;
                m_pf[fs]   = rdy_pf;
                m_drop[fs] = 1'b0;
                m_id[fs]   = rdy_pf ? bus.pf_req_id : bus.dm_req_id;
                ie.slot    = SLOT_W'(fs);
                ie.addr    = rdy_pf ? bus.pf_req_addr : bus.dm_req_addr;
                icq.push_back(ie);
            end
            if (rdy_pf) m_starve = 0;
            else if (bus.pf_req_valid && !starved) m_starve++;
        end
        @(posedge clk);
        @(negedge clk);
        ic_seen   = bus.ic_req_valid;
        last_slot = int'(bus.ic_req_id);
        if (icq.size() > 0) begin
            ie = icq.pop_front();
            check("ic_req_valid", val_t'(bus.ic_req_valid), val_t'(1'b1));
            check("ic_req_id", val_t'(bus.ic_req_id), val_t'(ie.slot));
            check("ic_req_addr", val_t'(bus.ic_req_addr), val_t'(ie.addr));
        end else begin
            check("ic_req_idle", val_t'(bus.ic_req_valid), val_t'(1'b0));
        end
        if (rspq.size() > 0) begin
            re = rspq.pop_front();
            if (re.pf) begin
                check("pf_rsp_valid", val_t'(bus.pf_rsp_valid), val_t'(1'b1));
                check("dm_rsp_quiet", val_t'(bus.dm_rsp_valid), val_t'(1'b0));
                check("pf_rsp_id", val_t'(bus.pf_rsp_id), val_t'(re.id));
                check("pf_rsp_data", bus.pf_rsp_data, re.data);
            end else begin
                check("dm_rsp_valid", val_t'(bus.dm_rsp_valid), val_t'(1'b1));
                check("pf_rsp_quiet", val_t'(bus.pf_rsp_valid), val_t'(1'b0));
                check("dm_rsp_id", val_t'(bus.dm_rsp_id), val_t'(re.id));
                check("dm_rsp_data", bus.dm_rsp_data, re.data);
            end
        end else begin
            check("dm_rsp_idle", val_t'(bus.dm_rsp_valid), val_t'(1'b0));
            check("pf_rsp_idle", val_t'(bus.pf_rsp_valid), val_t'(1'b0));
        end
    endtask

    task automatic idle_inputs();
        bus.flush        = 1'b0;
        bus.dm_req_valid = 1'b0;
        bus.pf_req_valid = 1'b0;
        bus.ic_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pf, second_pf;
        idle_inputs();
        bus.dm_req_id   = '0;
        bus.dm_req_addr = '0;
        bus.pf_req_id   = '0;
        bus.pf_req_addr = '0;
        bus.ic_rsp_id   = '0;
        bus.ic_rsp_data = '0;
        for (int i = 0; i < int'(MAX_OUTST); i++) begin
            m_busy[i] = 1'b0;
            m_pf[i]   = 1'b0;
            m_drop[i] = 1'b0;
            m_id[i]   = '0;
        end

        // Reset with a request pending: ready must stay low.
        bus.dm_req_valid = 1'b1;
        repeat (3) tick();
        bus.dm_req_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Single demand request and its response.
        bus.dm_req_valid = 1'b1;
        bus.dm_req_id    = 4'd3;
        bus.dm_req_addr  = 32'h40;
        tick();
        check("single_slot0", val_t'(last_slot), val_t'(0));
        bus.dm_req_valid = 1'b0;
        respond(0);
        tick();
        bus.ic_rsp_valid = 1'b0;
        tick();

        // Both requesters always valid, icache answers the cycle after each request.
        first_pf  = -1;
        second_pf = -1;
        bus.dm_req_valid = 1'b1;
        bus.pf_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.dm_req_id   = ID_W'(i);
            bus.dm_req_addr = 32'h1000 + 32'(i * 64);
            bus.pf_req_id   = ID_W'(15 - i);
            bus.pf_req_addr = 32'h8000 + 32'(i * 64);
            if (ic_seen) respond(last_slot);
            else bus.ic_rsp_valid = 1'b0;
            tick();
            if (acc_pf) begin
                if (first_pf < 0) first_pf = i;
                else if (second_pf < 0) second_pf = i;
            end
        end
        check("starve_first_pf", val_t'(first_pf), val_t'(8));
        check("starve_second_pf", val_t'(second_pf), val_t'(17));
        bus.dm_req_valid = 1'b0;
        bus.pf_req_valid = 1'b0;
        if (ic_seen) respond(last_slot);
        tick();
        bus.ic_rsp_valid = 1'b0;
        tick();

        // Fill the table, stay full while prefetch starves, then reuse the freed slot.
        bus.dm_req_valid = 1'b1;
        bus.pf_req_valid = 1'b1;
        bus.pf_req_id    = 4'hC;
        bus.pf_req_addr  = 32'hC000;
        for (int i = 0; i < 4; i++) begin
            bus.dm_req_id   = ID_W'(4 + i);
            bus.dm_req_addr = 32'h2000 + 32'(i * 64);
            tick();
        end
        tick();
        check("full_no_accept", val_t'(acc_dm | acc_pf), val_t'(1'b0));
        repeat (5) tick();
        respond(2);
        tick();
        check("no_same_cycle_reuse", val_t'(acc_dm | acc_pf), val_t'(1'b0));
        bus.ic_rsp_valid = 1'b0;
        tick();
        check("reuse_pf_wins", val_t'(acc_pf), val_t'(1'b1));
        check("reuse_slot2", val_t'(last_slot), val_t'(2));
        bus.dm_req_valid = 1'b0;
        bus.pf_req_valid = 1'b0;
        respond(0); tick();
        respond(1); tick();
        respond(3); tick();
        respond(2); tick();
        bus.ic_rsp_valid = 1'b0;
        tick();

        // Flush with two outstanding, the prefetch allocated just before the flush.
        bus.dm_req_valid = 1'b1;
        bus.dm_req_id    = 4'd1;
        bus.dm_req_addr  = 32'h3000;
        tick();
        bus.dm_req_valid = 1'b0;
        bus.pf_req_valid = 1'b1;
        bus.pf_req_id    = 4'd7;
        bus.pf_req_addr  = 32'h3040;
        tick();
        bus.pf_req_valid = 1'b0;
        bus.flush        = 1'b1;
        tick();
        bus.flush = 1'b0;
        respond(0); tick();
        respond(1); tick();
        bus.ic_rsp_valid = 1'b0;
        tick();
        bus.dm_req_valid = 1'b1;
        bus.dm_req_id    = 4'd5;
        bus.dm_req_addr  = 32'h3080;
        tick();
        check("post_flush_accept", val_t'(acc_dm), val_t'(1'b1));
        check("post_flush_slot0", val_t'(last_slot), val_t'(0));
        bus.dm_req_valid = 1'b0;
        respond(0); tick();
        bus.ic_rsp_valid = 1'b0;
        tick();

        // Out-of-order responses.
        bus.dm_req_valid = 1'b1;
        bus.dm_req_id    = 4'd9;
        bus.dm_req_addr  = 32'h4000;
        tick();
        bus.dm_req_valid = 1'b0;
        bus.pf_req_valid = 1'b1;
        bus.pf_req_id    = 4'hA;
        bus.pf_req_addr  = 32'h4040;
        tick();
        bus.pf_req_valid = 1'b0;
        respond(1); tick();
        check("ooo_pf_first", val_t'(bus.pf_rsp_id), val_t'(4'hA));
        respond(0); tick();
        check("ooo_dm_second", val_t'(bus.dm_rsp_id), val_t'(4'd9));
        bus.ic_rsp_valid = 1'b0;
        tick();

        // Reset with three slots busy.
        bus.dm_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dm_req_id   = ID_W'(1 + i);
            bus.dm_req_addr = 32'h5000 + 32'(i * 64);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.dm_req_id   = 4'd4;
        bus.dm_req_addr = 32'h6000;
        tick();
        check("after_reset_slot0", val_t'(last_slot), val_t'(0));
        bus.dm_req_valid = 1'b0;
        respond(0); tick();
        bus.ic_rsp_valid = 1'b0;
        tick();

        check("icq_drained", val_t'(icq.size()), val_t'(0));
        check("rspq_drained", val_t'(rspq.size()), val_t'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ic_req_arb.md
IC_REQ_ARB -- requirements
Module: ic_req_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter ID_W, default 4, requester transaction id width.
REQ-003 SHALL have parameter CL_BITS, default 512, cache-line data width.
REQ-004 SHALL have parameter MAX_OUTST, default 4, outstanding-slot count (power of 2, >=2); SLOT_W = log2(MAX_OUTST).
REQ-005 SHALL have parameter STARVE_LIM, default 8, prefetch starvation limit (1..255).
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  discard all outstanding transactions.
REQ-009 dm_req_valid  input  1  demand-fetch request valid.
REQ-010 dm_req_ready  output  1  demand request accepted this cycle when valid&ready.
REQ-011 dm_req_id  input  ID_W  demand transaction id.
REQ-012 dm_req_addr  input  ADDR_W  demand line address.
REQ-013 pf_req_valid / pf_req_ready / pf_req_id / pf_req_addr  same directions and widths as the dm_req_* ports, prefetch requester.
REQ-014 ic_req_valid  output  1  request to icache (no backpressure).
REQ-015 ic_req_id  output  SLOT_W  slot index used as icache id.
REQ-016 ic_req_addr  output  ADDR_W  forwarded address.
REQ-017 ic_rsp_valid  input  1  icache response valid.
REQ-018 ic_rsp_id  input  SLOT_W  slot index returned by icache.
REQ-019 ic_rsp_data  input  CL_BITS  line data.
REQ-020 dm_rsp_valid / dm_rsp_id / dm_rsp_data  output  1 / ID_W / CL_BITS  response to demand requester, original id restored.
REQ-021 pf_rsp_valid / pf_rsp_id / pf_rsp_data  output  1 / ID_W / CL_BITS  response to prefetch requester.

Function
REQ-022 SHALL hold a MAX_OUTST-entry slot table: busy, owner (dm/pf), original id, drop.
REQ-023 SHALL accept at most one request per cycle; ready is asserted only to the arbitration winner, only when at least one slot is free per registered busy state, and never while flush=1.
REQ-024 Arbitration: demand wins over prefetch unless the starvation counter equals STARVE_LIM, then prefetch wins.
REQ-025 Starvation counter: +1 per cycle with pf_req_valid=1 and no pf acceptance, saturating at STARVE_LIM; cleared on pf acceptance.
REQ-026 On acceptance SHALL allocate the lowest-index free slot, record owner/id, clear drop.
REQ-027 SHALL drive ic_req_valid/id/addr registered, exactly one cycle after acceptance; ic_req_valid=0 otherwise.
REQ-028 On ic_rsp_valid for a busy slot SHALL free it; the slot is allocatable from the next cycle (no same-cycle free-and-reuse).
REQ-029 SHALL drive the owner's rsp_valid/id/data registered, one cycle after ic_rsp_valid, unless drop is set or flush=1 that cycle; the other requester's rsp_valid stays 0.
REQ-030 Total added latency: 1 cycle request path, 1 cycle response path.
REQ-031 flush=1 SHALL set drop on every busy slot, including a slot allocated in the preceding cycle whose ic_req issues during the flush cycle; dropped responses free the slot silently.
REQ-032 Response to a non-busy slot SHALL be ignored (no state change, no forward); simulation SHALL flag an error.
REQ-033 Table full: both ready=0 until a slot frees; starvation counter continues counting.

Reset
REQ-034 While reset=0: all slots free, drop clear, starvation counter 0, ic_req_valid, dm_rsp_valid, pf_rsp_valid, dm_req_ready, pf_req_ready all 0; in-flight icache responses arriving after reset release are ignored per REQ-032.

Verification
REQ-035 Single demand id=3 addr=0x40 -> ic_req_valid at +1 with slot 0; icache rsp slot 0 -> dm_rsp_valid at +1, id=3, data matches; pf_rsp_valid stays 0.
REQ-036 dm and pf valid every cycle, STARVE_LIM=8, fast responses -> pf accepted once after 8 cycles of dm wins, counter then 0.
REQ-037 Issue 4 demand requests without responses -> both ready=0 on cycle 5; respond slot 2 -> next accepted request uses slot 2, one cycle after the response.
REQ-038 2 outstanding (dm id=1, pf id=7), flush pulse, then both responses -> no rsp_valid on either port, both slots free, new request accepted.
REQ-039 Out-of-order responses slots 1 then 0 -> outputs in same order, original ids restored per owner.
REQ-040 Reset asserted with 3 slots busy -> all outputs 0 next cycle; after release, first request gets slot 0.
